// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: derives pipeline-register
// enables, bubbles/flushes and PC select, plus stall/flush counters and a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             memwb_bubble,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t             state_reg;
  logic [WAIT_W-1:0]  wait_cnt_reg;
  logic               err_reg;
  logic [CNT_W-1:0]   stall_cnt_reg;
  logic [CNT_W-1:0]   flush_cnt_reg;

  logic memhold;
  logic loaduse;
  logic freeze;
  logic stall_ev;
  logic flush_ev;

  assign memhold = mem_req & ~dmem_ready;
  assign loaduse = ex_memread & (ex_rt != 5'd0) &
                   ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  // Once a wait has started only dmem_ready matters; mem_req is still asserted by the held MEM stage.
  always_comb begin
    freeze = 1'b1;
    case (state_reg)
      RUN:      freeze = memhold;
      MEM_WAIT: freeze = ~dmem_ready;
      default:  freeze = 1'b1;
    endcase
  end

  always_comb begin
    pc_we        = 1'b1;
    pc_src       = 2'b00;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_we      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_we     = 1'b1;
    memwb_bubble = 1'b0;
    stall_ev     = 1'b0;
    flush_ev     = 1'b0;
    if (!rst_n) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      exmem_we     = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (freeze) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      exmem_we     = 1'b0;
      memwb_bubble = 1'b1;
      stall_ev     = (state_reg != ERR);
    end else if (ex_branch_taken) begin
      // The ID instruction is squashed, so a concurrent load-use or jump is moot.
      pc_src      = 2'b01;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_ev    = 1'b1;
    end else if (loaduse) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
      stall_ev    = 1'b1;
    end else if (id_jump) begin
      pc_src     = 2'b10;
      ifid_flush = 1'b1;
      flush_ev   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= '0;
      err_reg       <= 1'b0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (memhold) begin
            state_reg    <= MEM_WAIT;
            wait_cnt_reg <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
          end else if (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT)) begin
            state_reg <= ERR;
            err_reg   <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
          end
        end
        default: ;
      endcase
      if (stall_ev && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (flush_ev && (flush_cnt_reg != {CNT_W{1'b1}}))
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  assign err       = err_reg;
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule
